event_delay_scheduler: RTL and testbench



---
 rtl/event_delay_scheduler.sv | 132 +++++++++++++
 tb/tb_event_delay_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/event_delay_scheduler.sv
// Delays each accepted event by its own runtime-chosen number of ticks.
// Events are released strictly in arrival order from a small pending queue.
module event_delay_scheduler #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [CNT_W-1:0]           in_delay,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PEND_W = $clog2(DEPTH+1);
    localparam int TW     = CNT_W + 1;

    logic [TW-1:0]     timer_reg;
    logic [TW-1:0]     timer_next;
    logic [WIDTH-1:0]  data_mem [DEPTH];
    logic [TW-1:0]     due_mem  [DEPTH];
    logic [DEPTH-1:0]  expired_reg;
    logic [DEPTH-1:0]  expired_next;
    logic [DEPTH-1:0]  slot_due;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PEND_W-1:0] count_reg;
    logic [PEND_W-1:0] count_next;
    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_data_reg;

    logic              q_empty;
    logic              out_free;
    logic              accept;
    logic              release_head;
    logic              bypass;
    logic              enqueue;
    logic [TW-1:0]     due_new;

    // Expiry is judged against the timer value of the next cycle so that an
    // entry moved at this edge is visible exactly D+1 cycles after acceptance.
    assign timer_next = timer_reg + 1'b1;
    assign due_new    = timer_reg + TW'(in_delay) + 1'b1;

    // Once due, a slot stays due even if it ages past half the timer range
    // while the output is stalled.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [TW-1:0] age;
            assign age              = timer_next - due_mem[gi];
            assign slot_due[gi]     = expired_reg[gi] || !age[TW-1];
            assign expired_next[gi] = (enqueue && (wr_ptr_reg == PTR_W'(gi))) ? 1'b0 : slot_due[gi];
        end
    endgenerate

    assign q_empty      = (count_reg == '0);
    assign out_free     = !out_valid_reg || out_ready;
    assign in_ready     = (count_reg != PEND_W'(DEPTH)) && !flush;
    assign accept       = in_valid && in_ready;
    assign release_head = !q_empty && slot_due[rd_ptr_reg] && out_free && !flush;
    // A zero-delay event arriving at an empty queue goes straight to the output.
    assign bypass       = accept && q_empty && (in_delay == '0) && out_free;
    assign enqueue      = accept && !bypass;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({enqueue, release_head})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enqueue) begin
            data_mem[wr_ptr_reg] <= in_data;
            due_mem[wr_ptr_reg]  <= due_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            expired_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            timer_reg   <= timer_next;
            count_reg   <= count_next;
            expired_reg <= expired_next;
            if (flush) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                out_valid_reg <= 1'b0;
                out_data_reg  <= '0;
            end else begin
                if (enqueue) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (release_head) begin
                    rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= data_mem[rd_ptr_reg];
                end else if (bypass) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= in_data;
                end else if (out_valid_reg && out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign pending   = count_reg;

endmodule

// File: tb/tb_event_delay_scheduler.sv
// Checks event_delay_scheduler cycle by cycle against an absolute-time model:
// every event becomes releasable at (accept cycle + 1 + delay), in FIFO order.
module tb_event_delay_scheduler;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int PW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [CNT_W-1:0] in_delay = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [PW-1:0]    pending;

    event_delay_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_delay(in_delay),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               rdy;
    } ev_t;

    ev_t              q[$];
    logic             m_ov = 1'b0;
    logic [WIDTH-1:0] m_od = '0;
    int               cyc = 0;
    bit               known = 1'b0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        bit acc;
        if (reset) begin
            q.delete();
            m_ov  = 1'b0;
            m_od  = '0;
            known = 1'b1;
            $display("cycle %0d: reset", cyc);
        end else if (flush) begin
            q.delete();
            m_ov = 1'b0;
            m_od = '0;
            $display("cycle %0d: flush", cyc);
        end else begin
            acc = in_valid && (q.size() != DEPTH);
            if (m_ov && out_ready)
                $display("cycle %0d: released data %02h", cyc, m_od);
            if (acc)
                q.push_back('{data: in_data, rdy: cyc + 1 + int'(in_delay)});
            if (!m_ov || out_ready) begin
                if (q.size() > 0 && q[0].rdy <= cyc + 1) begin
                    m_ov = 1'b1;
                    m_od = q[0].data;
                    void'(q.pop_front());
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] dl,
                        input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        in_data   = d;
        in_delay  = dl;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
        if (known) begin
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("out_data", 32'(out_data), 32'(m_od));
            check("pending", 32'(pending), 32'(q.size()));
            check("in_ready", 32'(in_ready), 32'((q.size() != DEPTH) && !fl));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        int rprob;
        int vprob;
        int r;
        logic [CNT_W-1:0] dl;
        int rtab[4] = '{100, 60, 10, 0};
        int vtab[4] = '{80, 40, 90, 30};

        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        // single event, delay 3
        idle(3, 1'b1);
        step(1'b1, 8'hA5, 4'd3, 1'b1, 1'b0, 1'b0);
        idle(8, 1'b1);
        // zero delay back-to-back
        step(1'b1, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h02, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h03, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        // full queue with head-of-line blocking, fifth offer refused
        step(1'b1, 8'hA0, 4'd10, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hB0, 4'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hC0, 4'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hD0, 4'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hE0, 4'd1, 1'b1, 1'b0, 1'b0);
        idle(16, 1'b1);
        // backpressure, including a stall longer than the timer half-range
        step(1'b1, 8'h11, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(40, 1'b0);
        idle(5, 1'b1);
        // flush with one presented and two queued entries
        step(1'b1, 8'h31, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h32, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h34, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(20, 1'b1);
        // same scenario ended by reset
        step(1'b1, 8'h41, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h43, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(20, 1'b1);

        rprob = 100;
        vprob = 80;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                rprob = rtab[$urandom_range(0, 3)];
                vprob = vtab[$urandom_range(0, 3)];
            end
            r = $urandom_range(0, 3);
            dl = (r == 0) ? '0 : (r == 1) ? '1 : CNT_W'($urandom_range(0, 15));
            step(($urandom_range(0, 99) < vprob), WIDTH'($urandom), dl,
                 ($urandom_range(0, 99) < rprob),
                 ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 999) == 0));
        end
        idle(40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
